// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the debug-word source and the 7-segment scan driver.
// Master supplies the word, decimal points, load strobe and blanking mode; slave drives the display pins.
interface seg7_scan_driver_if;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic        load_i;
    logic        blank_lz_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    modport master (
        output data_i, dp_i, load_i, blank_lz_i,
        input  an_o, seg_o, dp_o, frame_o
    );

    modport slave (
        input  data_i, dp_i, load_i, blank_lz_i,
        output an_o, seg_o, dp_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a 32-bit word as 8 hex digits on a common-anode display.
// New words are staged and committed only at the frame boundary, so a frame never tears.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_digit;
    logic [31:0]      r_shadow_data;
    logic [7:0]       r_shadow_dp;
    logic [31:0]      r_pend_data;
    logic [7:0]       r_pend_dp;
    logic             r_pend_valid;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame;

    logic             w_div_end;
    logic             w_boundary;
    logic [4:0]       w_bit_base;
    logic [3:0]       w_nibble;
    logic [31:0]      w_upper;
    logic             w_blank;
    logic [6:0]       w_seg_dec;

    assign w_div_end  = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_div_end && (r_digit == 3'd7);
    assign w_bit_base = {r_digit, 2'b00};
    assign w_nibble   = r_shadow_data[w_bit_base +: 4];
    // Digit k is a leading zero when every nibble from k upward is zero.
    assign w_upper    = r_shadow_data >> w_bit_base;
    assign w_blank    = bus.blank_lz_i && (r_digit != 3'd0) && (w_upper == 32'd0);

    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nibble)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_digit   <= 3'd0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_div_end) begin
                r_div_cnt <= '0;
                r_digit   <= r_digit + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // A load landing on the boundary goes straight to the shadow and supersedes any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_data <= 32'd0;
            r_shadow_dp   <= 8'd0;
            r_pend_data   <= 32'd0;
            r_pend_dp     <= 8'd0;
            r_pend_valid  <= 1'b0;
        end else if (w_boundary) begin
            r_pend_valid <= 1'b0;
            if (bus.load_i) begin
                r_shadow_data <= bus.data_i;
                r_shadow_dp   <= bus.dp_i;
            end else if (r_pend_valid) begin
                r_shadow_data <= r_pend_data;
                r_shadow_dp   <= r_pend_dp;
            end
        end else if (bus.load_i) begin
            r_pend_data  <= bus.data_i;
            r_pend_dp    <= bus.dp_i;
            r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_blank) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(8'b1 << r_digit);
            r_seg <= w_seg_dec;
            r_dp  <= ~r_shadow_dp[r_digit];
        end
    end

    assign bus.an_o    = r_an;
    assign bus.seg_o   = r_seg;
    assign bus.dp_o    = r_dp;
    assign bus.frame_o = r_frame;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads, every cycle compared
// against a frame-level model of what the display should show.
module tb_seg7_scan_driver;
    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seg7_scan_driver_if bus_if ();

    seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    logic [6:0] hex_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: cycles since reset release, what is on screen, and what waits for the next frame.
    int          m_c;
    logic [31:0] m_shadow;
    logic [7:0]  m_sdp;
    logic [31:0] m_pend;
    logic [7:0]  m_pdp;
    logic        m_pv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_c      = 0;
        m_shadow = 32'd0;
        m_sdp    = 8'd0;
        m_pend   = 32'd0;
        m_pdp    = 8'd0;
        m_pv     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [16:0] obs;
        obs = {bus_if.an_o, bus_if.seg_o, bus_if.dp_o, bus_if.frame_o};
        checks++;
        assert (obs === {8'hFF, 7'h7F, 1'b1, 1'b0}) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end
    endtask

    // One clock: predict the registered outputs from the model, advance the model, compare.
    task automatic step();
        int          dg;
        logic        bl;
        logic        bnd;
        logic        ld;
        logic [31:0] d;
        logic [7:0]  dpv;
        logic [16:0] exp_v;
        logic [16:0] obs;
        dg  = (m_c / DIV) % 8;
        bnd = ((m_c % FRAME) == FRAME - 1);
        bl  = 1'b0;
        if (bus_if.blank_lz_i && dg != 0) begin
            bl = 1'b1;
            for (int k = dg; k < 8; k++)
                if (m_shadow[4*k +: 4] != 4'h0) bl = 1'b0;
        end
        if (bl) exp_v = {8'hFF, 7'h7F, 1'b1, bnd};
        else    exp_v = {~(8'd1 << dg), hex_tab[m_shadow[4*dg +: 4]], ~m_sdp[dg], bnd};
        ld  = bus_if.load_i;
        d   = bus_if.data_i;
        dpv = bus_if.dp_i;
        @(posedge clk);
        if (bnd) begin
            if (ld) begin
                m_shadow = d;
                m_sdp    = dpv;
            end else if (m_pv) begin
                m_shadow = m_pend;
                m_sdp    = m_pdp;
            end
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = d;
            m_pdp  = dpv;
            m_pv   = 1'b1;
        end
        m_c++;
        #1;
        bus_if.load_i = 1'b0;
        obs = {bus_if.an_o, bus_if.seg_o, bus_if.dp_o, bus_if.frame_o};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL scan c=%0d an/seg/dp/frame observed=%h expected=%h", m_c, obs, exp_v);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge to be taken sits at the given position within the frame.
    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (m_c % FRAME) != phase; i++) step();
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] dpv);
        bus_if.data_i = d;
        bus_if.dp_i   = dpv;
        bus_if.load_i = 1'b1;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus_if.data_i     = 32'd0;
        bus_if.dp_i       = 8'd0;
        bus_if.load_i     = 1'b0;
        bus_if.blank_lz_i = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset_initial");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;

        // Idle scan with nothing loaded.
        run(2 * FRAME);

        // Load during digit 3: stays hidden until the frame boundary.
        run_to(3 * DIV + 1);
        load(32'h1234ABCD, 8'h01);
        run(2 * FRAME);

        // Leading-zero blanking.
        bus_if.blank_lz_i = 1'b1;
        load(32'h000000A5, 8'h00);
        run(2 * FRAME);
        bus_if.blank_lz_i = 1'b0;

        // Load exactly on the boundary cycle, with an older pending word to be discarded.
        run_to(5);
        load(32'h0BADF00D, 8'hFF);
        run_to(FRAME - 1);
        load(32'hFFFFFFFF, 8'h00);
        run(FRAME + 2);

        // Two loads in one frame: last wins.
        run_to(2);
        load(32'h11111111, 8'h00);
        run(3);
        load(32'h22222222, 8'h00);
        run(2 * FRAME);

        // All-zero word with blanking shows a single "0".
        bus_if.blank_lz_i = 1'b1;
        load(32'h00000000, 8'h00);
        run(2 * FRAME);
        bus_if.blank_lz_i = 1'b0;

        // Reset mid-dwell of digit 5 with a load pending.
        run_to(5 * DIV + 1);
        load(32'h87654321, 8'hF0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_async_midframe");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_midframe_held");
        rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        // Random loads, data with varying leading zeros, blanking toggled live.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ((i % 8) == 0) bus_if.blank_lz_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                bus_if.data_i = $urandom >> (4 * $urandom_range(0, 7));
                bus_if.dp_i   = 8'($urandom);
                bus_if.load_i = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
